iomem_cmd_master: RTL and testbench

Byte-stream-to-iomem bridge acting as an initiator on the PicoSoC iomem bus. It sits between a UART receiver/transmitter byte pair and the same iomem responders the CPU addresses, such as the GPIO register at 0x03xx_xxxx. It is used for host-driven debug and bring-up. Each command frame received as bytes becomes exactly one iomem read or write, and a response frame is returned on the transmit byte stream.

---
 rtl/iomem_cmd_master.sv | 186 ++++++++++++++++++
 tb/tb_iomem_cmd_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_cmd_master.sv
// Byte-stream command bridge: each received frame becomes one iomem read or write, answered on the tx byte stream.
// Define IOMEM_CMD_TIMEOUT_EN to abort transfers that see no iomem_ready within TIMEOUT valid cycles.
module iomem_cmd_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [23:0] tx_sr_q, tx_sr_d;
  logic [1:0]  tx_left_q, tx_left_d;
  logic        iomem_valid_q, iomem_valid_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        rx_take;

`ifdef IOMEM_CMD_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign rx_take = rx_valid && rx_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    tx_sr_d   = tx_sr_q;
    tx_left_d = tx_left_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef IOMEM_CMD_TIMEOUT_EN
    // Reloaded every cycle outside BUS so the first valid cycle starts at TIMEOUT-1.
    tmo_d     = TW'(TIMEOUT - 1);
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_take) begin
          if (rx_data == 8'h50) begin
            is_wr_d = 1'b0;
            wstrb_d = 4'h0;
            state_d = S_ADDR;
          end else if (rx_data[7:4] == 4'hA && rx_data[3:0] != 4'h0) begin
            is_wr_d = 1'b1;
            wstrb_d = rx_data[3:0];
            state_d = S_ADDR;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h3F;
            tx_left_d  = 2'd0;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_take) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = is_wr_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (rx_take) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (iomem_ready) begin
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
          if (is_wr_q) begin
            tx_data_d = 8'h4B;
            tx_left_d = 2'd0;
          end else begin
            tx_data_d = iomem_rdata[31:24];
            tx_sr_d   = iomem_rdata[23:0];
            tx_left_d = 2'd3;
          end
        end
`ifdef IOMEM_CMD_TIMEOUT_EN
        else if (tmo_q == '0) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'hEE;
          tx_left_d  = 2'd0;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (tx_ready) begin
          if (tx_left_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = tx_sr_q[23:16];
            tx_sr_d   = {tx_sr_q[15:0], 8'h00};
            tx_left_d = tx_left_q - 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Control outputs are registered copies of the next state.
    rx_ready_d    = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    iomem_valid_d = (state_d == S_BUS);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      is_wr_q       <= 1'b0;
      rx_ready_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_sr_q       <= 24'h0;
      tx_left_q     <= 2'd0;
      iomem_valid_q <= 1'b0;
      wstrb_q       <= 4'h0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      busy_q        <= 1'b0;
`ifdef IOMEM_CMD_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_wr_q       <= is_wr_d;
      rx_ready_q    <= rx_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      tx_sr_q       <= tx_sr_d;
      tx_left_q     <= tx_left_d;
      iomem_valid_q <= iomem_valid_d;
      wstrb_q       <= wstrb_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      busy_q        <= busy_d;
`ifdef IOMEM_CMD_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign iomem_valid = iomem_valid_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_iomem_cmd_master.sv
// Scoreboard bench for iomem_cmd_master: frames push expected bus transfers and response bytes,
// separate monitors for the iomem side and the tx side pop and compare.
module tb_iomem_cmd_master;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  iomem_cmd_master #(.TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .busy(busy)
  );

  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} txn_t;

  int n_tests = 0;
  int n_fail = 0;
  txn_t exp_bus[$];
  logic [7:0] exp_tx[$];
  bit mon_en = 1'b1;
  bit hold_off = 1'b0;
  bit spur = 1'b0;
  bit spur_active = 1'b0;
  bit tx_stall = 1'b0;
  bit in_txn = 1'b0;
  int force_lat = -1;
  int lat = 0;
  int vcnt = 0;
  txn_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder read data: a fixed scramble of the address.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
  endfunction

  // iomem responder and bus-side checker
  always @(negedge clk) if (mon_en) begin
    if (iomem_ready) begin
      iomem_ready = 1'b0;
      check("valid_low_after_ready", iomem_valid, 0);
      if (spur_active) begin
        spur_active = 1'b0;
        check("spurious_ready_no_tx", tx_valid, 0);
        check("spurious_ready_idle", busy, 0);
      end else begin
        check("tx_after_ready", tx_valid, 1);
        check("valid_cycles", vcnt, lat + 1);
        in_txn = 1'b0;
      end
    end else if (iomem_valid) begin
      if (!in_txn) begin
        check("bus_txn_expected", exp_bus.size() > 0, 1);
        if (exp_bus.size() > 0) begin
          cur = exp_bus.pop_front();
          check("bus_addr", iomem_addr, cur.addr);
          check("bus_wstrb", iomem_wstrb, cur.wstrb);
          if (cur.wstrb != 4'h0) check("bus_wdata", iomem_wdata, cur.wdata);
        end
        in_txn = 1'b1;
        vcnt = 0;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end else begin
        check("bus_addr_stable", iomem_addr, cur.addr);
        check("bus_wstrb_stable", iomem_wstrb, cur.wstrb);
      end
      vcnt++;
      if (!hold_off && vcnt == lat + 1) begin
        iomem_ready = 1'b1;
        iomem_rdata = rd_val(iomem_addr);
      end
    end else if (in_txn) begin
      check("timeout_valid_cycles", vcnt, 16);
      in_txn = 1'b0;
    end else if (spur) begin
      spur = 1'b0;
      spur_active = 1'b1;
      iomem_ready = 1'b1;
      iomem_rdata = 32'h1234_5678;
    end
  end

  // tx sink and response checker
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int scnt = 0;
  always @(negedge clk) if (mon_en) begin
    if (tx_valid) begin
      check("tx_byte_expected", exp_tx.size() > 0, 1);
      if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx[0]);
      if (prev_stall) check("tx_data_stable", tx_data, prev_data);
      if (tx_stall) begin
        if (scnt < 5) begin tx_ready = 1'b0; scnt++; end
        else begin tx_ready = 1'b1; scnt = 0; end
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      if (tx_ready && exp_tx.size() > 0) void'(exp_tx.pop_front());
      prev_stall = !tx_ready;
      prev_data = tx_data;
    end else begin
      tx_ready = 1'($urandom_range(0, 1));
      prev_stall = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    for (int i = 0; i < 3000; i++) begin
      if (rx_ready) break;
      @(negedge clk);
    end
    check("rx_accept", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // mode: 0 normal, 1 expect timeout response, 2 transfer will be abandoned by reset
  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input int maxgap, input int mode);
    bit rd, wr;
    logic [31:0] r;
    txn_t t;
    rd = (op == 8'h50);
    wr = (op >= 8'hA1 && op <= 8'hAF);
    if (rd || wr) begin
      t.addr = addr;
      t.wdata = data;
      t.wstrb = wr ? op[3:0] : 4'h0;
      exp_bus.push_back(t);
    end
    if (mode == 1) exp_tx.push_back(8'hEE);
    else if (mode == 0) begin
      if (rd) begin
        r = rd_val(addr);
        for (int k = 0; k < 4; k++) exp_tx.push_back(r[31-8*k -: 8]);
      end else if (wr) exp_tx.push_back(8'h4B);
      else exp_tx.push_back(8'h3F);
    end
    send_byte(op, int'($urandom_range(0, maxgap)));
    if (rd || wr)
      for (int k = 0; k < 4; k++) send_byte(addr[31-8*k -: 8], int'($urandom_range(0, maxgap)));
    if (wr)
      for (int k = 0; k < 4; k++) send_byte(data[31-8*k -: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      if (exp_tx.size() == 0 && exp_bus.size() == 0 && !busy && !in_txn) break;
      @(negedge clk);
    end
    check("drain_tx", exp_tx.size(), 0);
    check("drain_bus", exp_bus.size(), 0);
    check("idle_after_frame", busy, 0);
  endtask

  initial begin
    logic [7:0] op;
    int r;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rx_ready, tx_valid, tx_data, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, busy}, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", rx_ready, 1);
    check("busy_after_reset", busy, 0);

    force_lat = 1;
    send_frame(8'hA1, 32'h0300_0000, 32'h0000_005A, 0, 0);
    wait_idle();
    force_lat = -1;
    send_frame(8'h50, 32'h0300_0000, 32'h0, 0, 0);
    wait_idle();

    send_frame(8'h51, 32'h0, 32'h0, 0, 0);
    send_frame(8'hA0, 32'h0, 32'h0, 0, 0);
    wait_idle();

    send_frame(8'hAF, 32'h0300_0004, 32'hCAFE_F00D, 3, 0);
    send_frame(8'h50, 32'h0300_0004, 32'h0, 3, 0);
    wait_idle();

    tx_stall = 1'b1;
    send_frame(8'h50, 32'h1234_5678, 32'h0, 0, 0);
    send_frame(8'hA3, 32'h0300_0008, 32'h0102_0304, 0, 0);
    wait_idle();
    tx_stall = 1'b0;

    spur = 1'b1;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 7));
      if (r < 3) op = 8'h50;
      else if (r < 6) op = 8'hA0 | 8'($urandom_range(1, 15));
      else op = 8'($urandom_range(0, 255));
      send_frame(op, $urandom, $urandom, (n % 2) * 2, 0);
    end
    wait_idle();

`ifdef IOMEM_CMD_TIMEOUT_EN
    hold_off = 1'b1;
    send_frame(8'h50, 32'h0300_0010, 32'h0, 0, 1);
    wait_idle();
    hold_off = 1'b0;
    spur = 1'b1;
    repeat (4) @(negedge clk);
    force_lat = 15;
    send_frame(8'h50, 32'h0300_0014, 32'h0, 0, 0);
    wait_idle();
    force_lat = -1;
    send_frame(8'hA7, 32'h0300_0018, 32'h5555_AAAA, 0, 0);
    wait_idle();
`endif

    hold_off = 1'b1;
    send_frame(8'h50, 32'h0300_0020, 32'h0, 0, 2);
    for (int i = 0; i < 100; i++) begin
      if (in_txn) break;
      @(negedge clk);
    end
    check("bus_reached_before_reset", iomem_valid, 1);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("reset_in_bus_outputs",
          {rx_ready, tx_valid, tx_data, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, busy}, 0);
    resetn = 1'b1;
    in_txn = 1'b0;
    hold_off = 1'b0;
    prev_stall = 1'b0;
    exp_bus.delete();
    exp_tx.delete();
    @(negedge clk);
    check("rx_ready_after_release", rx_ready, 1);
    mon_en = 1'b1;
    send_frame(8'h50, 32'h0300_0024, 32'h0, 0, 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
